// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine
//   N x N output-stationary systolic array computing C = A x B on unsigned
//   operands. Operand beats (one column of A plus one row of B per beat) are
//   buffered, then fed into the array edges with the diagonal skew generated
//   here. Once the array has settled, result rows drain one per handshake.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   in_valid     operand beat valid
//   in_ready     engine accepts an operand beat (LOAD only)
//   in_a_col     beat k: column k of A, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_b_row     beat k: row k of B, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   out_valid    result row valid
//   out_ready    sink accepts result row
//   out_row      row r of C, element j at [j*ACC_WIDTH +: ACC_WIDTH]
//   out_row_idx  index of the presented row (0 when out_valid is low)
//   out_last     high with out_valid on row N-1
//   busy         high in COMPUTE or DRAIN
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | accepting operand beats into the A/B buffers
// COMPUTE | feeding skewed operands through the array, then padding
// DRAIN   | presenting result rows 0..N-1 on the output stream

module systolic_matmul_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 3,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a_col,
  input  logic [N*DATA_WIDTH-1:0] in_b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*ACC_WIDTH-1:0]  out_row,
  output logic [$clog2(N)-1:0]    out_row_idx,
  output logic                    out_last,
  output logic                    busy
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(3*N);
  // Last feed step that can still carry a non-zero operand pair into PE(N-1,N-1).
  localparam logic [TW-1:0] T_LAST_FEED = TW'(3*N-3);
  // Two padding steps after the last feed so out_valid rises 3N edges after
  // the final operand beat.
  localparam logic [TW-1:0] T_DONE      = TW'(3*N-1);
  localparam logic [IW-1:0] IDX_LAST    = IW'(N-1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   load_cnt;
  logic [IW-1:0]   row_cnt;
  logic [TW-1:0]   feed_cnt;

  logic            beat_accept, last_beat, row_xfer, last_row;
  logic            acc_clr, acc_en;

  logic [DATA_WIDTH-1:0] a_buf [N][N];  // [beat k][row i]   = A[i][k]
  logic [DATA_WIDTH-1:0] b_buf [N][N];  // [beat k][column j] = B[k][j]

  logic [TW-1:0]         feed_off [N];
  logic                  feed_hit [N];
  logic [DATA_WIDTH-1:0] a_edge   [N];
  logic [DATA_WIDTH-1:0] b_edge   [N];

  // Inter-PE pipeline: a flows right (no register needed past the last
  // column), b flows down (none past the last row).
  logic [DATA_WIDTH-1:0] a_pe    [N][N-1];
  logic [DATA_WIDTH-1:0] b_pe    [N-1][N];
  logic [ACC_WIDTH-1:0]  acc_arr [N][N];

  // Handshakes are qualified by state directly so they do not loop through
  // the FSM's own output decode.
  assign beat_accept = in_valid && (state == LOAD);
  assign last_beat   = beat_accept && (load_cnt == IDX_LAST);
  assign row_xfer    = out_ready && (state == DRAIN);
  assign last_row    = row_xfer && (row_cnt == IDX_LAST);
  assign acc_clr     = last_beat;
  assign acc_en      = (state == COMPUTE) && (feed_cnt <= T_LAST_FEED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        busy = 1'b1;
        if (feed_cnt == T_DONE) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (last_row) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_cnt <= '0;
      feed_cnt <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        LOAD: begin
          feed_cnt <= '0;
          if (beat_accept) begin
            load_cnt <= last_beat ? '0 : load_cnt + IW'(1);
          end
        end
        COMPUTE: begin
          feed_cnt <= (feed_cnt == T_DONE) ? '0 : feed_cnt + TW'(1);
        end
        DRAIN: begin
          if (row_xfer) begin
            row_cnt <= last_row ? '0 : row_cnt + IW'(1);
          end
        end
        default: begin
          load_cnt <= '0;
          feed_cnt <= '0;
          row_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        for (int e = 0; e < N; e++) begin
          a_buf[k][e] <= '0;
          b_buf[k][e] <= '0;
        end
      end
    end else if (beat_accept) begin
      for (int e = 0; e < N; e++) begin
        a_buf[load_cnt][e] <= in_a_col[e*DATA_WIDTH +: DATA_WIDTH];
        b_buf[load_cnt][e] <= in_b_row[e*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Edge skew: row i sees A[i][t-i], column j sees B[t-j][j]; both use the
  // same offset t-g, so one offset per edge lane serves both operands.
  for (genvar g = 0; g < N; g++) begin : g_edge
    assign feed_off[g] = feed_cnt - TW'(g);
    assign feed_hit[g] = (state == COMPUTE) && (feed_cnt >= TW'(g)) &&
                         (feed_off[g] < TW'(N));
    assign a_edge[g]   = feed_hit[g] ? a_buf[feed_off[g][IW-1:0]][g] : '0;
    assign b_edge[g]   = feed_hit[g] ? b_buf[feed_off[g][IW-1:0]][g] : '0;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DATA_WIDTH-1:0]   a_src, b_src;
      logic [2*DATA_WIDTH-1:0] prod;
      logic [ACC_WIDTH-1:0]    acc_q;

      if (gj == 0) begin : g_a_from_edge
        assign a_src = a_edge[gi];
      end else begin : g_a_from_left
        assign a_src = a_pe[gi][gj-1];
      end

      if (gi == 0) begin : g_b_from_edge
        assign b_src = b_edge[gj];
      end else begin : g_b_from_above
        assign b_src = b_pe[gi-1][gj];
      end

      assign prod = {{DATA_WIDTH{1'b0}}, a_src} * {{DATA_WIDTH{1'b0}}, b_src};

      // Casting to ACC_WIDTH zero-extends, or wraps if the width is overridden small.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_q <= '0;
        end else if (acc_clr) begin
          acc_q <= '0;
        end else if (acc_en) begin
          acc_q <= acc_q + ACC_WIDTH'(prod);
        end
      end
      assign acc_arr[gi][gj] = acc_q;

      if (gj < N-1) begin : g_a_reg
        logic [DATA_WIDTH-1:0] a_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            a_q <= '0;
          end else if (acc_clr) begin
            a_q <= '0;
          end else if (acc_en) begin
            a_q <= a_src;
          end
        end
        assign a_pe[gi][gj] = a_q;
      end

      if (gi < N-1) begin : g_b_reg
        logic [DATA_WIDTH-1:0] b_q;
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            b_q <= '0;
          end else if (acc_clr) begin
            b_q <= '0;
          end else if (acc_en) begin
            b_q <= b_src;
          end
        end
        assign b_pe[gi][gj] = b_q;
      end
    end
  end

  // Accumulators are frozen in DRAIN, so the presented row holds under backpressure.
  always_comb begin
    out_row     = '0;
    out_row_idx = '0;
    out_last    = 1'b0;
    if (out_valid) begin
      out_row_idx = row_cnt;
      out_last    = (row_cnt == IDX_LAST);
      for (int j = 0; j < N; j++) begin
        out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc_arr[row_cnt][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
module tb_systolic_matmul_engine;

  localparam int DW = 8;
  localparam int N  = 3;
  localparam int AW = 2*DW + $clog2(N);

  typedef logic [8:0][DW-1:0] mat_t;
  typedef logic [8:0][AW-1:0] res_t;

  typedef struct packed {
    mat_t       a;
    mat_t       b;
    res_t       expv;
    logic       gap;
    logic       pulse;
    logic [1:0] stall_row;
    logic [3:0] stall_cycles;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_a_col = '0;
  logic [N*DW-1:0] in_b_row = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*AW-1:0] out_row;
  logic [1:0]      out_row_idx;
  logic            out_last;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  systolic_matmul_engine #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a_col    (in_a_col),
    .in_b_row    (in_b_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row     (out_row),
    .out_row_idx (out_row_idx),
    .out_last    (out_last),
    .busy        (busy)
  );

  function automatic mat_t m8(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {DW'(e8), DW'(e7), DW'(e6), DW'(e5), DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
  endfunction

  function automatic res_t mr(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {AW'(e8), AW'(e7), AW'(e6), AW'(e5), AW'(e4), AW'(e3), AW'(e2), AW'(e1), AW'(e0)};
  endfunction

  // Reference: plain row-by-column dot products.
  function automatic res_t model(input mat_t a, input mat_t b);
    res_t res;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        longint sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(a[r*N+k]) * longint'(b[k*N+c]);
        res[r*N+c] = AW'(sum);
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beats(input vec_t v);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) in_a_col[i*DW +: DW] = v.a[i*N+k];
      for (int j = 0; j < N; j++) in_b_row[j*DW +: DW] = v.b[k*N+j];
      tick();
      if (k == 0 && v.gap) begin
        in_valid = 1'b0;
        in_a_col = (N*DW)'($urandom());
        in_b_row = (N*DW)'($urandom());
        repeat (3) tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic check_row(input string tag, input vec_t v, input int r);
    check($sformatf("%s out_valid r%0d", tag, r), longint'(out_valid), 1);
    check($sformatf("%s idx r%0d", tag, r), longint'(out_row_idx), r);
    check($sformatf("%s last r%0d", tag, r), longint'(out_last), (r == N-1) ? 1 : 0);
    for (int j = 0; j < N; j++) begin
      check($sformatf("%s C[%0d][%0d]", tag, r, j),
            longint'(out_row[j*AW +: AW]), longint'(v.expv[r*N+j]));
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int cyc;
    load_beats(v);
    check({tag, " busy after load"}, longint'(busy), 1);
    check({tag, " in_ready in compute"}, longint'(in_ready), 0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      if (v.pulse && cyc == 1) begin
        in_valid = 1'b1;
        in_a_col = (N*DW)'($urandom());
        in_b_row = (N*DW)'($urandom());
      end
      if (cyc == 3) in_valid = 1'b0;
      if (cyc == 5) begin
        check({tag, " idx while idle"}, longint'(out_row_idx), 0);
        check({tag, " last while idle"}, longint'(out_last), 0);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, cyc, 3*N);
    for (int r = 0; r < N; r++) begin
      if (r == int'(v.stall_row) && v.stall_cycles != 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < int'(v.stall_cycles); s++) begin
          tick();
          check_row({tag, " stalled"}, v, r);
        end
        out_ready = 1'b1;
      end
      check_row(tag, v, r);
      tick();
    end
    check({tag, " out_valid after drain"}, longint'(out_valid), 0);
    check({tag, " busy after drain"}, longint'(busy), 0);
    check({tag, " in_ready after drain"}, longint'(in_ready), 1);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    mat_t a_ex, b_ex;
    res_t c_ex;
    int   seen;

    a_ex = m8(7, 4, 7, 5, 6, 9, 1, 9, 5);
    b_ex = m8(2, 5, 3, 7, 9, 5, 8, 5, 7);
    c_ex = mr(98, 106, 90, 124, 124, 108, 105, 111, 83);

    v = '0; v.a = a_ex; v.b = b_ex; v.expv = c_ex;
    vecs.push_back(v);
    v = '0;
    v.a = m8(255, 255, 255, 255, 255, 255, 255, 255, 255);
    v.b = v.a;
    v.expv = mr(195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075);
    vecs.push_back(v);
    v = '0; v.a = m8(1, 0, 0, 0, 1, 0, 0, 0, 1); v.b = b_ex;
    v.expv = mr(2, 5, 3, 7, 9, 5, 8, 5, 7);
    vecs.push_back(v);
    v = '0;
    vecs.push_back(v);
    v = '0; v.a = a_ex; v.b = b_ex; v.expv = c_ex; v.stall_row = 2'd1; v.stall_cycles = 4'd5;
    vecs.push_back(v);
    v = '0; v.a = a_ex; v.b = b_ex; v.expv = c_ex; v.gap = 1'b1; v.pulse = 1'b1;
    vecs.push_back(v);
    for (int n = 0; n < 5; n++) begin
      v = '0;
      for (int e = 0; e < 9; e++) begin
        v.a[e] = DW'($urandom_range(0, 255));
        v.b[e] = DW'($urandom_range(0, 255));
      end
      v.expv         = model(v.a, v.b);
      v.gap          = 1'($urandom_range(0, 1));
      v.pulse        = 1'($urandom_range(0, 1));
      v.stall_row    = 2'($urandom_range(0, 2));
      v.stall_cycles = 4'($urandom_range(0, 3));
      vecs.push_back(v);
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset busy", longint'(busy), 0);
    check("reset out_row", longint'(out_row), 0);
    check("reset out_row_idx", longint'(out_row_idx), 0);
    check("reset out_last", longint'(out_last), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    foreach (vecs[n]) run_job(vecs[n], $sformatf("vec%0d", n));

    // Abort mid-COMPUTE at feed step 4.
    v = '0; v.a = a_ex; v.b = b_ex; v.expv = c_ex;
    load_beats(v);
    repeat (4) tick();
    check("pre-abort busy", longint'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort out_valid", longint'(out_valid), 0);
    check("abort in_ready", longint'(in_ready), 1);
    check("abort busy", longint'(busy), 0);
    check("abort out_row", longint'(out_row), 0);
    check("abort out_row_idx", longint'(out_row_idx), 0);
    check("abort out_last", longint'(out_last), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (15) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort no output", seen, 0);
    run_job(v, "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Parametrised N×N output-stationary systolic matrix-multiply engine computing C = A×B on unsigned operands.
- Successor to the fixed 3×3 array: edge skewing is generated internally, so the host does not hand-skew operands.
- Operands load through a valid/ready stream. Results drain row by row through a second valid/ready stream.
- Sits between an operand buffer/DMA front end and a result sink.

Parameters:
- DATA_WIDTH, 8, operand width in bits (unsigned).
- N, 3, array dimension (N ≥ 2); computes N×N by N×N.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N), accumulator and result width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts an operand beat.
- in_a_col  in  N*DATA_WIDTH  beat k: column k of A, element i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_b_row  in  N*DATA_WIDTH  beat k: row k of B, element j at bits [j*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result row valid.
- out_ready  in  1  sink accepts result row.
- out_row  out  N*ACC_WIDTH  row r of C, element j at bits [j*ACC_WIDTH +: ACC_WIDTH].
- out_row_idx  out  $clog2(N)  index r of the presented row.
- out_last  out  1  high with out_valid on row N-1.
- busy  out  1  high in COMPUTE or DRAIN.

Behaviour:
- Reset (rst low, asynchronous):
  - state=LOAD; all counters, operand buffers, PE accumulators and PE pipeline registers = 0.
  - in_ready=1; out_valid=0; out_row=0; out_row_idx=0; out_last=0; busy=0.
  - Reset asserted mid-COMPUTE or mid-DRAIN aborts the job; no partial output is produced afterwards.
- LOAD state:
  - in_ready=1.
  - A beat transfers on an edge with in_valid&&in_ready. It is stored at buffer index k, then k increments.
  - in_valid low stalls loading with no effect.
  - On the edge accepting beat N-1: state→COMPUTE, in_ready→0, busy→1. All N² accumulators clear on that same edge.
- COMPUTE state:
  - Feed counter t runs 0..3N-3.
  - Left edge of row i receives A[i][t-i]; top edge of column j receives B[t-j][j]. Out-of-range indices inject 0.
  - Each PE(i,j) registers a rightward and b downward each cycle and accumulates acc += a*b, with full-width product, zero-extended.
  - ACC_WIDTH is sized so the sum cannot overflow; if it is overridden smaller, results wrap modulo 2^ACC_WIDTH.
  - The pipeline is padded so that out_valid rises exactly 3N edges after the edge accepting the last operand beat (9 cycles at N=3). At that point state→DRAIN.
- DRAIN state:
  - Presents rows r=0..N-1 in order; out_row = {acc(r,N-1)..acc(r,0)}.
  - A row transfers on an edge with out_valid&&out_ready, then r increments.
  - While out_valid&&!out_ready, out_row, out_row_idx and out_last hold stable.
  - out_valid never drops without a transfer.
  - With out_ready held high, one row transfers per cycle (N cycles total).
  - On the edge transferring row N-1: state→LOAD, out_valid→0, busy→0, in_ready→1 on the next cycle.
- Operand port:
  - in_ready is 0 throughout COMPUTE and DRAIN.
  - in_valid asserted then is ignored, with no buffering or overwrite.
- Back-to-back jobs: each job starts from cleared accumulators; no residue from the previous job.
- out_row_idx and out_last are 0 whenever out_valid=0.

Test Plan:
- Load A={{7,4,7},{5,6,9},{1,9,5}}, B={{2,5,3},{7,9,5},{8,5,7}} with out_ready=1:
  - out_valid rises 9 cycles after the last beat.
  - Rows {98,106,90}, {124,124,108}, {105,111,83} arrive on consecutive cycles.
  - out_last is high on row 2.
- All operands 255:
  - Every element = 195075 with no overflow in the 18-bit result.
- Identity A with the B above:
  - Output equals B.
  - Then a second job with A=B=0 returns all zeros, proving accumulator clear.
- Output backpressure:
  - Hold out_ready=0 for 5 cycles on row 1; row 1 data and idx stay stable.
  - Total job still yields the correct 3 rows with none dropped or duplicated.
- Load gaps and ignored input:
  - Deassert in_valid between beats 0 and 1 for 3 cycles; the result is unchanged.
  - in_valid pulsed during COMPUTE does not alter results.
- Async reset mid-COMPUTE (t=4):
  - All outputs immediately 0 and in_ready=1.
  - A subsequent fresh job produces the correct product.
